uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_param.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, receiver FSM state
// encoding and a ceil-log2 helper used to size counters.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick divider.
// Ports:
//   clock - system clock
//   reset - asynchronous active-high reset
//   tick  - one-cycle pulse every CLKS_PER_TICK clocks (constant high when 1)
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = 1
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = clog2(CLKS_PER_TICK);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // With CLKS_PER_TICK=1 the counter is pinned at 0, so tick stays high.
    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with ready/valid output register.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   rx            - asynchronous serial input, idles high
//   data_out      - received word, LSB first on the wire
//   data_valid    - data_out holds an unconsumed word
//   data_ready    - consumer accept
//   parity_err    - parity result for data_out
//   frame_err     - stop-bit result for data_out
//   overrun_err   - sticky: a frame completed while data_valid was high
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int OVERSAMPLE    = 16,
    parameter int CLKS_PER_TICK = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int HALF   = OVERSAMPLE / 2;
    localparam int CNT_W  = clog2(OVERSAMPLE);
    localparam int BIT_W  = clog2(((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS) + 1);

    logic             sync1, rx_s, rx_prev;
    logic             tick;
    rx_state_t        state, state_next;
    logic [CNT_W-1:0] tick_cnt, tick_limit;
    logic [BIT_W-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic             perr_acc, ferr_acc, done;
    logic             fall, bit_done;
    logic             frame_start, shift_en, par_en, stop_en, last_stop;
    logic             accept;

    uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Synchroniser plus one history flop for edge detection; all idle high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign fall       = rx_prev & ~rx_s;
    // START waits half a bit to land mid-bit; every later sample is one bit apart.
    assign tick_limit = (state == ST_START) ? CNT_W'(HALF - 1) : CNT_W'(OVERSAMPLE - 1);
    assign bit_done   = tick && (tick_cnt == tick_limit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        shift_en    = 1'b0;
        par_en      = 1'b0;
        stop_en     = 1'b0;
        last_stop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_next  = ST_START;
                    frame_start = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) state_next = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1))
                        state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    par_en     = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    stop_en = 1'b1;
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        last_stop  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame datapath. shift/perr_acc/ferr_acc stay stable through the
    // completion cycle, so the output register can load them directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last_stop;
            if (state == ST_IDLE || bit_done) tick_cnt <= '0;
            else if (tick)                    tick_cnt <= tick_cnt + 1'b1;
            if (state_next != state) bit_cnt <= '0;
            else if (bit_done)       bit_cnt <= bit_cnt + 1'b1;
            if (frame_start) begin
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
            end
            if (shift_en) shift <= {rx_s, shift[DATA_BITS-1:1]};
            // Odd mode inverts the sense: error when the overall XOR is 0.
            if (par_en) perr_acc <= (^{shift, rx_s}) ^ (PARITY == PARITY_ODD);
            if (stop_en && !rx_s) ferr_acc <= 1'b1;
        end
    end

    assign accept = data_valid && data_ready;

    // Output holding register. A completion on the same edge as an accept
    // overrides the accept's clear of data_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (accept) begin
                data_valid  <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift;
                    parity_err <= perr_acc;
                    frame_err  <= ferr_acc;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: instance A is 8N1 (OVERSAMPLE=16, tick every clock),
// instance B is 8E2 (OVERSAMPLE=8, tick every 2 clocks); both run 16 clocks/bit.
// Expected words are queued when a frame is sent; a monitor compares on transfer.
module tb_uart_rx_param;

    localparam int BIT_CLKS = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic ready_a = 1'b0, ready_b = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b;

    always #5 clock = ~clock;

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .CLKS_PER_TICK(1)) dut_a (
        .clock(clock), .reset(reset), .rx(rx_a), .data_out(dout_a), .data_valid(valid_a),
        .data_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(ovr_a));

    uart_rx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(8), .CLKS_PER_TICK(2)) dut_b (
        .clock(clock), .reset(reset), .rx(rx_b), .data_out(dout_b), .data_valid(valid_b),
        .data_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(ovr_b));

    typedef struct {
        logic [7:0] data;
        bit perr;
        bit ferr;
        bit ovr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   hold_a = 1'b0, hold_b = 1'b0;
    int   cyc = 0;
    int   rise_cyc = -1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: ready is decided first, so a valid&&ready seen here is the
    // transfer that happens on the coming rising edge.
    initial begin
        exp_t e;
        bit chk_a, chk_b;
        chk_a = 0;
        chk_b = 0;
        forever begin
            @(negedge clock);
            if (chk_a) begin
                check("a_valid_after_accept", valid_a, 0);
                check("a_ovr_after_accept", ovr_a, 0);
                chk_a = 0;
            end
            if (chk_b) begin
                check("b_valid_after_accept", valid_b, 0);
                check("b_ovr_after_accept", ovr_b, 0);
                chk_b = 0;
            end
            ready_a = !hold_a;
            ready_b = !hold_b;
            if (valid_a && rise_cyc < 0) rise_cyc = cyc;
            if (valid_a && ready_a) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_unexpected_word: got %0h, expected none", dout_a);
                end else begin
                    e = q_a.pop_front();
                    check("a_data", dout_a, e.data);
                    check("a_perr", perr_a, e.perr);
                    check("a_ferr", ferr_a, e.ferr);
                    check("a_ovr", ovr_a, e.ovr);
                end
                chk_a = 1;
            end
            if (valid_b && ready_b) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected_word: got %0h, expected none", dout_b);
                end else begin
                    e = q_b.pop_front();
                    check("b_data", dout_b, e.data);
                    check("b_perr", perr_b, e.perr);
                    check("b_ferr", ferr_b, e.ferr);
                    check("b_ovr", ovr_b, e.ovr);
                end
                chk_b = 1;
            end
        end
    end

    task automatic drive(input int inst, input logic v, input int clks);
        if (inst == 0) rx_a = v;
        else           rx_b = v;
        repeat (clks) @(negedge clock);
    endtask

    // Queue the expected word per the receiver's rules, then drive the frame.
    // Instance 0 is 8N1; instance 1 is 8E2 with a correct parity bit unless flipped.
    task automatic send(input int inst, input logic [7:0] data, input bit flip_par, input logic [1:0] stopv);
        int   nstop;
        logic pbit;
        exp_t e, h;
        nstop  = (inst == 0) ? 1 : 2;
        pbit   = (^data) ^ flip_par;
        e.data = data;
        e.perr = (inst == 1) && flip_par;
        e.ferr = (stopv[0] == 1'b0) || (nstop == 2 && stopv[1] == 1'b0);
        e.ovr  = 0;
        if (inst == 0) begin
            if (hold_a && q_a.size() > 0) begin
                h = q_a[0]; h.ovr = 1; q_a[0] = h;
            end else q_a.push_back(e);
        end else begin
            if (hold_b && q_b.size() > 0) begin
                h = q_b[0]; h.ovr = 1; q_b[0] = h;
            end else q_b.push_back(e);
        end
        drive(inst, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(inst, data[i], BIT_CLKS);
        if (inst == 1) drive(inst, pbit, BIT_CLKS);
        for (int s = 0; s < nstop; s++) drive(inst, stopv[s], BIT_CLKS);
        // A low stop bit leaves the line low; restore idle so the next start edge exists.
        if (stopv[nstop-1] == 1'b0) drive(inst, 1'b1, BIT_CLKS);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid_a"}, valid_a, 0);
        check({tag, "_dout_a"}, dout_a, 0);
        check({tag, "_perr_a"}, perr_a, 0);
        check({tag, "_ferr_a"}, ferr_a, 0);
        check({tag, "_ovr_a"}, ovr_a, 0);
        check({tag, "_valid_b"}, valid_b, 0);
        check({tag, "_ovr_b"}, ovr_b, 0);
    endtask

    initial begin
        int   st_cyc;
        int   budget;
        logic [7:0] d;
        logic [1:0] sv;
        bit   fl;

        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (BIT_CLKS) @(negedge clock);

        // Basic 8N1 word with latency window.
        st_cyc = cyc;
        send(0, 8'hB5, 0, 2'b11);
        repeat (4) @(negedge clock);
        check("a_first_latency_ok", (rise_cyc - st_cyc >= 150) && (rise_cyc - st_cyc <= 165), 1);

        // Start glitch is rejected, then a valid frame.
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 3 * BIT_CLKS);
        send(0, 8'h3C, 0, 2'b11);

        // Bad stop bit.
        send(0, 8'h55, 0, 2'b10);

        // Overrun: hold the consumer off across two frames.
        hold_a = 1'b1;
        send(0, 8'h11, 0, 2'b11);
        send(0, 8'h22, 0, 2'b11);
        repeat (20) @(negedge clock);
        check("a_ovr_set", ovr_a, 1);
        check("a_held_word", dout_a, 8'h11);
        hold_a = 1'b0;
        repeat (4) @(negedge clock);

        // Reset in the middle of bit 4 of 0xA5.
        d = 8'hA5;
        drive(0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive(0, d[i], BIT_CLKS);
        drive(0, d[4], 8);
        reset = 1'b1;
        rx_a  = 1'b1;
        repeat (5) @(negedge clock);
        check_idle_outputs("midreset");
        reset = 1'b0;
        repeat (BIT_CLKS) @(negedge clock);
        send(0, 8'h5A, 0, 2'b11);

        // Break: one all-zero word with a framing error, then nothing until idle.
        begin
            exp_t e;
            e.data = 8'h00; e.perr = 0; e.ferr = 1; e.ovr = 0;
            q_a.push_back(e);
        end
        drive(0, 1'b0, 20 * BIT_CLKS);
        drive(0, 1'b1, 2 * BIT_CLKS);
        send(0, 8'hC3, 0, 2'b11);

        // 8E2 instance: parity and second-stop-bit cases.
        send(1, 8'h0F, 1, 2'b11);
        send(1, 8'h0F, 0, 2'b11);
        send(1, 8'h5A, 0, 2'b01);
        send(1, 8'h96, 0, 2'b10);

        // Randomized back-to-back frames on both instances.
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            sv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            send(0, d, 0, sv);
        end
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            fl = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            send(1, d, fl, sv);
        end

        budget = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && budget < 400) begin
            @(negedge clock);
            budget++;
        end
        repeat (4) @(negedge clock);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        check("a_valid_final", valid_a, 0);
        check("b_valid_final", valid_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
